// File: rtl/char_write_scheduler_pkg.sv
// Shared display constants and the scheduler state encoding.
// The display block imports the same geometry and blank code.
package char_write_scheduler_pkg;

  localparam int        CWS_NUM_COLS  = 80;
  localparam int        CWS_NUM_LINES = 60;
  localparam int        CWS_MAX_LEN   = 16;
  localparam logic [7:0] BLANK_CHAR   = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WRITE,
    ST_ACK
  } cws_state_e;

endpackage

// File: rtl/char_write_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

  assign grant_o = (req_i == 2'b11) ? ~last_i : req_i[1];

endmodule

// File: rtl/char_write_scheduler.sv
// Arbitrates two text-write requesters and streams one character per cycle
// into the character RAM, clipping anything that falls off the visible grid.
module char_write_scheduler
  import char_write_scheduler_pkg::*;
#(
  parameter int NUM_COLS  = CWS_NUM_COLS,
  parameter int NUM_LINES = CWS_NUM_LINES,
  parameter int MAX_LEN   = CWS_MAX_LEN
) (
  input  logic                 pixel_clock,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [6:0]           req_line0,
  input  logic [6:0]           req_line1,
  input  logic [6:0]           req_col0,
  input  logic [6:0]           req_col1,
  input  logic [4:0]           req_len0,
  input  logic [4:0]           req_len1,
  input  logic [8*MAX_LEN-1:0] req_text0,
  input  logic [8*MAX_LEN-1:0] req_text1,
  output logic [1:0]           ack,
  output logic                 busy,
  output logic [13:0]          char_addr,
  output logic [7:0]           char_write_data,
  output logic                 write_enable
);

  localparam int KW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  cws_state_e           state_q, state_d;
  logic                 gnt_q, last_q, arb_gnt;
  logic [6:0]           line_q, col_q;
  logic [4:0]           len_q;
  logic [KW-1:0]        k_q;
  logic [8*MAX_LEN-1:0] text_q;

  logic [6:0]           sel_line, sel_col;
  logic [4:0]           sel_len_raw, sel_len;
  logic [8*MAX_LEN-1:0] sel_text;
  logic [7:0]           col_sum;
  logic                 in_range;
  logic [7:0]           chars [MAX_LEN];

  rr_arbiter2 u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (arb_gnt)
  );

  assign sel_line    = gnt_q ? req_line1 : req_line0;
  assign sel_col     = gnt_q ? req_col1  : req_col0;
  assign sel_len_raw = gnt_q ? req_len1  : req_len0;
  assign sel_text    = gnt_q ? req_text1 : req_text0;
  assign sel_len     = (sel_len_raw > 5'(MAX_LEN)) ? 5'(MAX_LEN) : sel_len_raw;

  for (genvar c = 0; c < MAX_LEN; c++) begin : g_chars
    assign chars[c] = text_q[8*(MAX_LEN-1-c) +: 8];
  end

  // 8-bit sum so columns past 127 cannot wrap back into the visible range.
  assign col_sum  = {1'b0, col_q} + 8'(k_q);
  assign in_range = (col_sum < 8'(NUM_COLS)) && (line_q < 7'(NUM_LINES));

  always_comb begin
    state_d         = state_q;
    ack             = 2'b00;
    busy            = (state_q != ST_IDLE);
    write_enable    = 1'b0;
    char_addr       = '0;
    char_write_data = BLANK_CHAR;
    case (state_q)
      ST_IDLE:    if (|req) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (sel_len == 5'd0) ? ST_ACK : ST_WRITE;
      ST_WRITE: begin
        write_enable    = in_range;
        char_addr       = {line_q, col_sum[6:0]};
        char_write_data = chars[k_q];
        if (5'(k_q) == len_q - 5'd1) state_d = ST_ACK;
      end
      ST_ACK: begin
        ack     = gnt_q ? 2'b10 : 2'b01;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      line_q  <= '0;
      col_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      text_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (|req) begin
          gnt_q  <= arb_gnt;
          last_q <= arb_gnt;
        end
        ST_CAPTURE: begin
          line_q <= sel_line;
          col_q  <= sel_col;
          len_q  <= sel_len;
          text_q <= sel_text;
          k_q    <= '0;
        end
        ST_WRITE: k_q <= k_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_char_write_scheduler.sv
// Randomized and directed bench for char_write_scheduler against a
// transaction-level timeline model of grants, writes and acks.
module tb_char_write_scheduler;

  localparam int ML = 16;
  localparam int NC = 80;
  localparam int NL = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [6:0]    p_line [2];
  logic [6:0]    p_col  [2];
  logic [4:0]    p_len  [2];
  logic [8*ML-1:0] p_text [2];

  logic [1:0]    ack;
  logic          busy;
  logic [13:0]   char_addr;
  logic [7:0]    char_write_data;
  logic          write_enable;

  char_write_scheduler dut (
    .pixel_clock     (clk),
    .reset           (rst),
    .req             (req),
    .req_line0       (p_line[0]),
    .req_line1       (p_line[1]),
    .req_col0        (p_col[0]),
    .req_col1        (p_col[1]),
    .req_len0        (p_len[0]),
    .req_len1        (p_len[1]),
    .req_text0       (p_text[0]),
    .req_text1       (p_text[1]),
    .ack             (ack),
    .busy            (busy),
    .char_addr       (char_addr),
    .char_write_data (char_write_data),
    .write_enable    (write_enable)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a granted transfer occupies L+2 cycles after the grant edge:
  // t=0 capture, t=1..L writes char t-1, t=L+1 ack, then idle.
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  int          m_t, m_L, m_w;
  logic [6:0]  m_line, m_col;
  logic [8*ML-1:0] m_text;
  int          n_we, n_busy;
  int          ack_log [$];

  function automatic logic [7:0] char_at(input logic [8*ML-1:0] t, input int k);
    logic [8*ML-1:0] s;
    s = t >> (8*(ML-1-k));
    return s[7:0];
  endfunction

  function automatic logic [8*ML-1:0] mk_text(input string s);
    logic [8*ML-1:0] t;
    t = '0;
    for (int k = 0; k < s.len() && k < ML; k++) t[8*(ML-1-k) +: 8] = s[k];
    return t;
  endfunction

  function automatic logic [8*ML-1:0] rnd_text();
    logic [8*ML-1:0] t;
    for (int k = 0; k < ML; k++) t[8*k +: 8] = 8'($urandom_range(8'h21, 8'h7e));
    return t;
  endfunction

  task automatic post(input int i, input int line, input int col, input int len,
                      input logic [8*ML-1:0] text);
    p_line[i] = 7'(line);
    p_col[i]  = 7'(col);
    p_len[i]  = 5'(len);
    p_text[i] = text;
    req[i]    = 1'b1;
  endtask

  task automatic tick();
    int k, cs;
    bit wph, exp_we;
    logic [1:0] exp_ack;
    @(posedge clk);
    if (m_busy) begin
      m_t++;
      if (m_t > m_L + 1) m_busy = 1'b0;
    end else if (req != 2'b00) begin
      m_w    = (req == 2'b11) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
      m_last = (m_w == 1);
      m_busy = 1'b1;
      m_t    = 0;
      m_L    = (int'(p_len[m_w]) > ML) ? ML : int'(p_len[m_w]);
      m_line = p_line[m_w];
      m_col  = p_col[m_w];
      m_text = p_text[m_w];
    end
    #1;
    exp_ack = (m_busy && m_t == m_L + 1) ? ((m_w == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ack", 32'(ack), 32'(exp_ack));
    wph = m_busy && m_t >= 1 && m_t <= m_L;
    if (wph) begin
      k      = m_t - 1;
      cs     = int'(m_col) + k;
      exp_we = (cs < NC) && (int'(m_line) < NL);
      chk("we", 32'(write_enable), 32'(exp_we));
      if (exp_we) begin
        chk("addr", 32'(char_addr), 32'({m_line, 7'(cs)}));
        chk("data", 32'(char_write_data), 32'(char_at(m_text, k)));
      end
    end else begin
      chk("we_idle", 32'(write_enable), 32'd0);
      chk("addr_idle", 32'(char_addr), 32'd0);
      chk("data_idle", 32'(char_write_data), 32'h20);
    end
    if (write_enable) n_we++;
    if (busy) n_busy++;
    if (ack[0]) ack_log.push_back(0);
    if (ack[1]) ack_log.push_back(1);
    if (exp_ack != 2'b00) req[m_w] = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy || req != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    if (m_busy || req != 2'b00) chk("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int posts [2];
    int n;
    for (int i = 0; i < 2; i++) begin
      p_line[i] = '0; p_col[i] = '0; p_len[i] = '0; p_text[i] = '0;
    end
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_addr", 32'(char_addr), 32'd0);
    chk("rst_data", 32'(char_write_data), 32'h20);
    @(negedge clk) rst = 1'b0;

    // Both requesters at once out of reset, each re-requesting once.
    ack_log.delete();
    posts = '{1, 1};
    post(0, 2, 0, 3, rnd_text());
    post(1, 3, 0, 2, rnd_text());
    n = 0;
    while (ack_log.size() < 4 && n < 100) begin
      tick();
      n++;
      for (int i = 0; i < 2; i++)
        if (!req[i] && posts[i] < 2) begin
          post(i, 4 + i, 10, 2, rnd_text());
          posts[i]++;
        end
    end
    run_idle(100);
    chk("rr_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk("rr_order", 32'(ack_log[i]), 32'(i % 2));

    n_we = 0;
    post(0, 10, 1, 9, mk_text(" COUNT: 7"));
    run_idle(100);
    chk("count_writes", 32'(n_we), 32'd9);

    n_we = 0;
    post(1, 5, 76, 8, rnd_text());
    run_idle(100);
    chk("clip_writes", 32'(n_we), 32'd4);

    n_we = 0; n_busy = 0;
    post(0, 7, 7, 0, rnd_text());
    run_idle(100);
    chk("len0_writes", 32'(n_we), 32'd0);
    chk("len0_busy", 32'(n_busy), 32'd2);

    n_we = 0;
    post(1, 0, 0, 20, rnd_text());
    run_idle(100);
    chk("clamp_writes", 32'(n_we), 32'd16);

    n_we = 0;
    post(0, 61, 0, 4, rnd_text());
    run_idle(100);
    chk("line_clip", 32'(n_we), 32'd0);

    // Reset landing in the middle of the third write.
    post(0, 3, 0, 8, rnd_text());
    n = 0;
    while (!(m_busy && m_t == 3) && n < 50) begin
      tick();
      n++;
    end
    chk("abort_reach", 32'(m_busy && m_t == 3), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we", 32'(write_enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_addr", 32'(char_addr), 32'd0);
    m_busy = 1'b0;
    m_last = 1'b1;
    req    = 2'b00;
    @(negedge clk) rst = 1'b0;
    n_we = 0;
    post(0, 20, 30, 5, rnd_text());
    run_idle(100);
    chk("after_abort", 32'(n_we), 32'd5);

    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (!req[i] && $urandom_range(0, 2) == 0)
          post(i, $urandom_range(0, 70), $urandom_range(0, 127),
               $urandom_range(0, 20), rnd_text());
    end
    run_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
